// File: rtl/debug_pkg.sv
// Shared constants and helpers for the debug capture path.
package debug_pkg;

  // Fill policy when the buffer is full
  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_RING = 1'b1;

  // Frame and register widths shared with the UART receiver
  localparam int unsigned FRAME_W_DEF = 9;
  localparam int unsigned REG_W_DEF   = 4;

  // Ceiling log2; usable in constant expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/debug_capture_buffer_if.sv
// Capture/readout bus of the debug capture buffer.
interface debug_capture_buffer_if #(
  parameter int unsigned FRAME_W = debug_pkg::FRAME_W_DEF,
  parameter int unsigned REG_W   = debug_pkg::REG_W_DEF,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned OVF_W   = 8
);
  import debug_pkg::*;

  localparam int unsigned CNT_W = clog2(DEPTH) + 1;

  logic                     debug;
  logic                     mode;
  logic                     frame_valid;
  logic [FRAME_W-1:0]       frame;
  logic [REG_W-1:0]         data_out;
  logic                     rd_req;
  logic [FRAME_W-1:0]       debug_frame;
  logic [REG_W-1:0]         debug_reg;
  logic [REG_W+FRAME_W-1:0] rd_data;
  logic                     rd_valid;
  logic [CNT_W-1:0]         count;
  logic                     empty;
  logic                     full;
  logic [OVF_W-1:0]         ovf_cnt;

  // Block side
  modport slave (
    input  debug, mode, frame_valid, frame, data_out, rd_req,
    output debug_frame, debug_reg, rd_data, rd_valid, count, empty, full, ovf_cnt
  );

  // Driver / readout side
  modport master (
    output debug, mode, frame_valid, frame, data_out, rd_req,
    input  debug_frame, debug_reg, rd_data, rd_valid, count, empty, full, ovf_cnt
  );

endinterface

// File: rtl/debug_ring_fifo.sv
// Register-array FIFO with separate occupancy count, optional overwrite of
// the oldest entry when full, and a registered one-cycle-latency read port.
module debug_ring_fifo
  import debug_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             overwrite,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             wr_drop
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  logic pop, push, evict;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Pop is resolved first, so a write alongside a pop on a full buffer always fits
  always_comb begin
    pop     = rd_en && !empty;
    push    = wr_en && (!full || pop || overwrite);
    evict   = wr_en && full && !pop && overwrite;
    wr_drop = wr_en && full && !pop && !overwrite;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = (pop || evict) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push && !evict, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and read-port state with synchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Storage; contents are only exposed after being written, so no reset
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

endmodule

// File: rtl/debug_capture_buffer.sv
// Captures received frames with a register snapshot into a FIFO while debug
// is enabled; keeps the newest frame, the live register and a drop counter.
module debug_capture_buffer
  import debug_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_W_DEF,
  parameter int unsigned REG_W   = REG_W_DEF,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned OVF_W   = 8
) (
  input logic                   clk,
  input logic                   rst,
  debug_capture_buffer_if.slave bus
);

  localparam int unsigned ENTRY_W = REG_W + FRAME_W;

  logic               clr;
  logic               overwrite;
  logic               wr_drop;
  logic [FRAME_W-1:0] debug_frame_q, debug_frame_d;
  logic [REG_W-1:0]   debug_reg_q, debug_reg_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;

  assign clr       = !bus.debug;
  assign overwrite = (bus.mode == MODE_RING);

  debug_ring_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_en     (bus.frame_valid),
    .wr_data   ({bus.data_out, bus.frame}),
    .rd_en     (bus.rd_req),
    .overwrite (overwrite),
    .rd_data   (bus.rd_data),
    .rd_valid  (bus.rd_valid),
    .count     (bus.count),
    .empty     (bus.empty),
    .full      (bus.full),
    .wr_drop   (wr_drop)
  );

  // Next-state for the newest frame, live register and saturating drop counter
  always_comb begin
    debug_frame_d = bus.frame_valid ? bus.frame : debug_frame_q;
    debug_reg_d   = bus.data_out;
    ovf_d         = ovf_q;
    if (wr_drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
  end

  // Top-level state, cleared whenever debug is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debug_frame_q <= '0;
      debug_reg_q   <= '0;
      ovf_q         <= '0;
    end else if (clr) begin
      debug_frame_q <= '0;
      debug_reg_q   <= '0;
      ovf_q         <= '0;
    end else begin
      debug_frame_q <= debug_frame_d;
      debug_reg_q   <= debug_reg_d;
      ovf_q         <= ovf_d;
    end
  end

  assign bus.debug_frame = debug_frame_q;
  assign bus.debug_reg   = debug_reg_q;
  assign bus.ovf_cnt     = ovf_q;

endmodule

// File: doc/debug_capture_buffer.md
Name: debug_capture_buffer

Overview:
- Parametrised successor to the single-register debug frame latch.
- While debug is enabled, captures every valid received frame, tagged with a snapshot of the register value, into a DEPTH-entry buffer. Two fill policies are supported: stop-when-full and ring overwrite.
- Buffered entries are read out over a request/valid handshake. The newest frame and the live register value stay visible on dedicated outputs.
- Sits between the UART receive path / register file and the debug display / readout logic of the VGA design.

Parameters:
- FRAME_W, 9, width of a received frame.
- REG_W, 4, width of the register snapshot.
- DEPTH, 8, buffer entries; power of two, at least 2.
- OVF_W, 8, width of the dropped-frame counter; saturating.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- debug  in  1  capture enable; low clears the block.
- mode  in  1  0 = stop when full, 1 = ring (overwrite oldest).
- frame_valid  in  1  one-cycle strobe; frame is valid this cycle.
- frame  in  FRAME_W  received frame.
- data_out  in  REG_W  register value to snapshot.
- rd_req  in  1  read request for the oldest entry.
- debug_frame  out  FRAME_W  most recently captured frame.
- debug_reg  out  REG_W  data_out registered by one cycle.
- rd_data  out  REG_W+FRAME_W  {reg snapshot, frame} of the popped entry.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- count  out  clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf_cnt  out  OVF_W  frames dropped in stop mode; saturating.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0 and empty=1.
  - Pointers 0; storage contents don't-care.
- debug=0 at a clock edge:
  - Synchronous clear: pointers, count, ovf_cnt, debug_frame, debug_reg, rd_data and rd_valid all go to 0.
  - frame_valid and rd_req are ignored.
  - debug low for exactly one cycle is still a full clear.
- debug=1, capture:
  - On frame_valid, write {data_out, frame} at wr_ptr and set debug_frame <= frame, both on the same edge.
  - The snapshot uses data_out sampled on the frame_valid cycle.
- debug_reg:
  - Updates every cycle while debug=1: debug_reg <= data_out.
- Read:
  - rd_req with empty=0 pops the entry at rd_ptr.
  - The popped entry appears on rd_data the next cycle with rd_valid=1 for one cycle (latency 1).
  - rd_req while empty is ignored: rd_valid stays 0 and no error is raised.
  - rd_data holds its last value when rd_valid=0.
- Full, mode=0 (stop):
  - A write while full is dropped; debug_frame still updates.
  - ovf_cnt increments and saturates at all-ones.
- Full, mode=1 (ring):
  - A write while full overwrites the oldest entry; rd_ptr advances; count stays DEPTH; ovf_cnt unchanged.
- Simultaneous write and read, not full:
  - Both occur; count unchanged.
  - If empty, the read is ignored and the write proceeds.
- Simultaneous write and read, full:
  - The pop occurs first, then the write. count stays DEPTH and the write is never dropped in either mode.
  - rd_data returns the entry that was oldest before the edge.
- Pointers:
  - clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
  - count is tracked separately, so full/empty need no extra pointer bit.
- mode changes:
  - Take effect on the next write; buffer contents are kept.
- Storage:
  - Register array, no reset required.
  - Outputs never expose an unwritten entry.

Decomposition:
- Shared package debug_pkg holds:
  - localparams MODE_STOP=1'b0 and MODE_RING=1'b1.
  - A helper function for clog2.
  - Default FRAME_W and REG_W constants shared with the UART receiver.
- One natural sub-module: debug_ring_fifo, holding pointers, count, storage and the full/empty logic, with an overwrite-enable input.
- The top level handles debug clearing, the overflow counter, debug_frame/debug_reg and the mode policy.

Test Plan:
- Reset mid-capture: write 3 frames, assert rst asynchronously between edges -> all outputs 0 immediately, empty=1, count=0.
- Stop mode overflow: DEPTH=8, mode=0, write 10 frames 0x101..0x10A -> count=8, full=1, ovf_cnt=2, debug_frame=0x10A. Eight reads return 0x101..0x108, each rd_valid one cycle after its rd_req.
- Ring mode: mode=1, write 10 frames -> count=8, ovf_cnt=0. Reads return 0x103..0x10A in order, then empty=1.
- Simultaneous write/read when full: 8 entries, frame_valid and rd_req on the same edge -> rd_data = oldest entry, count stays 8, new frame is stored last; mode=0 gives no ovf_cnt increment.
- debug deassert: fill 5 entries with ovf_cnt=0, drop debug for 1 cycle -> count=0, debug_frame=0, debug_reg=0. rd_req then gives no rd_valid.
- Snapshot and empty read: data_out=0xA when frame_valid with frame=0x055 -> rd_data={0xA,0x055}. rd_req on an empty buffer -> rd_valid stays 0.
